// File: rtl/muldiv_sequencer.sv
// Multicycle MIPS MULT/MULTU/DIV/DIVU engine: shift-add multiply and restoring divide, one bit per cycle.
// Optional feature: define DIVZERO_TRAP_EN to short-circuit divide by zero with a div_zero pulse.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic             busy_next, done_next, div_zero_next;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  // work_hi: product high half (multiply) or WIDTH+1-bit partial remainder (divide)
  logic [WIDTH:0]   work_hi;
  // work_lo: multiplier shifting out (multiply) or dividend in / quotient out (divide)
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] opnd;
  logic             neg_lo, neg_hi;

  logic             is_div, is_signed, a_neg, b_neg, div_by_zero, run_last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand decode; raw operands sit in work_lo/opnd until PREP replaces them with magnitudes
  assign is_div      = op_q[1];
  assign is_signed   = ~op_q[0];
  assign a_neg       = is_signed & work_lo[WIDTH-1];
  assign b_neg       = is_signed & opnd[WIDTH-1];
  assign mag_a       = a_neg ? -work_lo : work_lo;
  assign mag_b       = b_neg ? -opnd : opnd;
  assign div_by_zero = is_div & (opnd == '0);
  assign run_last    = (cnt == CW'(WIDTH - 1));

  // One multiply step: conditional add, then shift {work_hi,work_lo} right
  assign mul_sum   = work_hi + (work_lo[0] ? {1'b0, opnd} : '0);

  // One restoring divide step: shift in the next dividend bit, subtract if it fits
  assign div_shift = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift - {1'b0, opnd};

  // Sign correction applied at FIX
  assign prod      = {work_hi[WIDTH-1:0], work_lo};
  assign prod_fix  = neg_lo ? -prod : prod;
  assign quo_fix   = neg_lo ? -work_lo : work_lo;
  assign rem_fix   = neg_hi ? -work_hi[WIDTH-1:0] : work_hi[WIDTH-1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and registered-output next values
  always_comb begin
    state_next    = state;
    busy_next     = busy;
    done_next     = 1'b0;
    div_zero_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_PREP;
          busy_next  = 1'b1;
        end
      end
      S_PREP: begin
`ifdef DIVZERO_TRAP_EN
        if (div_by_zero) begin
          state_next    = S_DONE;
          done_next     = 1'b1;
          div_zero_next = 1'b1;
        end else begin
          state_next = S_RUN;
        end
`else
        state_next = S_RUN;
`endif
      end
      S_RUN: begin
        if (run_last) state_next = S_FIX;
      end
      S_FIX: begin
        state_next = S_DONE;
        done_next  = 1'b1;
      end
      S_DONE: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy     <= busy_next;
      done     <= done_next;
      div_zero <= div_zero_next;
    end
  end

  // Datapath: operand latch, magnitude prep, iterations and HI/LO update
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q    <= 2'b00;
      cnt     <= '0;
      work_hi <= '0;
      work_lo <= '0;
      opnd    <= '0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            work_lo <= operand_a;
            opnd    <= operand_b;
            work_hi <= '0;
          end
        end
        S_PREP: begin
          neg_lo  <= a_neg ^ b_neg;
          neg_hi  <= is_div & a_neg;
          work_hi <= '0;
          cnt     <= '0;
          if (is_div) begin
            work_lo <= mag_a;
            opnd    <= mag_b;
          end else begin
            work_lo <= mag_b;
            opnd    <= mag_a;
          end
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            work_hi <= div_ge ? div_diff : div_shift;
            work_lo <= {work_lo[WIDTH-2:0], div_ge};
          end else begin
            {work_hi, work_lo} <= {1'b0, mul_sum, work_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes reference results, monitor pops on done.
// Honours DIVZERO_TRAP_EN in the reference model.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           blen;
    int           start;
  } exp_t;

  exp_t sb_q[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    e.dz = 1'b0; e.lat = 34; e.blen = 35; e.start = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: begin sp = sa * sb; up = sp; e.hi = up[63:32]; e.lo = up[31:0]; end
      2'b01: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
      default: begin
        if (b == '0) begin
`ifdef DIVZERO_TRAP_EN
          e.dz = 1'b1; e.lat = 1; e.blen = 2; e.hi = last_hi; e.lo = last_lo;
`else
          e.hi = a;
          e.lo = (o == 2'b10 && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
`endif
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          up = sq; e.lo = up[31:0];
          up = sr; e.hi = up[31:0];
        end else begin
          up = ua / ub; e.lo = up[31:0];
          up = ua % ub; e.hi = up[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_zero", 64'(div_zero), 64'(e.dz));
        check("done_latency", 64'(cyc - e.start), 64'(e.lat));
        check("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  // Driver: called at a negedge; returns at the negedge where busy has dropped
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit glitch);
    exp_t e;
    int k;
    e = model(o, a, b);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    e.start = cyc;
    sb_q.push_back(e);
    if (!e.dz) begin last_hi = e.hi; last_lo = e.lo; end
    check("busy_after_start", 64'(busy), 64'd1);
    k = 0;
    while (busy && k < 100) begin
      start = glitch && (k == 5 || done);
      if (start) begin
        op = 2'($urandom_range(0, 3)); operand_a = $urandom; operand_b = $urandom;
      end
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    check("busy_length", 64'(cyc - e.start), 64'(e.blen));
    check("hold_hi", 64'(hi), 64'(e.hi));
    check("hold_lo", 64'(lo), 64'(e.lo));
    if (glitch) begin
      @(negedge clock);
      check("idle_after_ignored_start", {62'b0, busy, done}, 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clock);
    check("reset_state", {busy, done, div_zero, hi, lo}, 67'd0);
    reset = 1'b0;

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd10, 32'd0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0);
    run_op(2'b10, 32'd25, 32'd0, 1'b0);
    run_op(2'b00, 32'h1234_5678, 32'h8765_4321, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      run_op(ro, ra, rb, ($urandom_range(0, 3) == 0));
    end

    // Abort: reset sampled on the 10th RUN edge (edge 11)
    op = 2'b01; operand_a = 32'hDEAD_BEEF; operand_b = 32'h0000_1234; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_state", {busy, done, div_zero, hi, lo}, 67'd0);
    last_hi = '0; last_lo = '0;
    reset = 1'b0;
    run_op(2'b00, 32'hFFFF_FFFF, 32'd5, 1'b0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
